// File: rtl/somador_pkg.sv
// -----------------------------------------------------------------------------
// somador_pkg
// Shared constants for the somador_completo full-adder block.
//   SOMADOR_WIDTH_DEFAULT : default operand/sum width (classic 1-bit cell)
//   SOMADOR_WIDTH_MAX     : widest supported operand/sum width
// -----------------------------------------------------------------------------
package somador_pkg;

  localparam int SOMADOR_WIDTH_DEFAULT = 1;
  localparam int SOMADOR_WIDTH_MAX     = 64;

endpackage : somador_pkg

// File: rtl/fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
// One-bit full adder, the leaf cell of the ripple-carry chain.
// Ports:
//   a, b : operand bits
//   ci   : carry-in
//   s    : sum bit       = a ^ b ^ ci
//   co   : carry-out bit = (a & b) | (ci & (a ^ b))
// -----------------------------------------------------------------------------
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Propagate term is shared by the sum and the carry equations.
  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);

endmodule : fa_cell

// File: rtl/somador_completo.sv
// -----------------------------------------------------------------------------
// somador_completo
// WIDTH-bit ripple-carry adder: {co, s} = a + b + ci.
// Built from WIDTH fa_cell instances with the carry chained bit to bit.
//
// Configuration macro: SOMADOR_REG_OUT_EN
//   defined   : s and co are registered on the rising edge of clk, with a
//               synchronous active-high reset (rst) that clears them.
//   undefined : s and co are purely combinational; clk and rst are unused.
//
// Parameters:
//   WIDTH : operand/sum width, 1..SOMADOR_WIDTH_MAX
// Ports:
//   clk  : system clock (registered mode only)
//   rst  : synchronous active-high reset (registered mode only)
//   a, b : unsigned operands, WIDTH bits
//   ci   : carry-in
//   s    : sum, WIDTH bits
//   co   : carry-out (bit WIDTH of the full sum)
// -----------------------------------------------------------------------------
module somador_completo
  import somador_pkg::*;
#(
  parameter int WIDTH = SOMADOR_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  if (WIDTH < 1 || WIDTH > SOMADOR_WIDTH_MAX) begin : g_width_check
    $error("somador_completo: WIDTH=%0d outside 1..%0d", WIDTH, SOMADOR_WIDTH_MAX);
  end

  // Carry chain: w_c[0] is the block carry-in, w_c[WIDTH] the carry-out.
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;

  assign w_c[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_cell u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (w_c[i]),
      .s  (w_s[i]),
      .co (w_c[i+1])
    );
  end

`ifdef SOMADOR_REG_OUT_EN
  logic [WIDTH-1:0] r_s;
  logic             r_co;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the reset is synchronous, so rst appears
  // only inside the clocked branch, never in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s  <= '0;
      r_co <= 1'b0;
    end else begin
      r_s  <= w_s;
      r_co <= w_c[WIDTH];
    end
  end

  assign s  = r_s;
  assign co = r_co;
`else
  // Combinational build: clk and rst are part of the port list but carry no
  // function; fold them into a sink so they are visibly consumed.
  logic w_unused_clk_rst;

  assign w_unused_clk_rst = clk ^ rst;
  assign s                = w_s;
  assign co               = w_c[WIDTH];
`endif

endmodule : somador_completo

// File: tb/tb_somador_completo.sv
// -----------------------------------------------------------------------------
// tb_somador_completo
// Directed self-checking bench for somador_completo. Instantiates WIDTH = 1,
// 4 and 8 copies sharing clk/rst. Follows SOMADOR_REG_OUT_EN: in registered
// builds results are checked one cycle after the inputs are applied.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_somador_completo;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // WIDTH = 1
  logic [0:0] a1 = '0, b1 = '0, s1;
  logic       ci1 = 1'b0, co1;
  // WIDTH = 4
  logic [3:0] a4 = '0, b4 = '0, s4;
  logic       ci4 = 1'b0, co4;
  // WIDTH = 8
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       ci8 = 1'b0, co8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  somador_completo #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .ci(ci1), .s(s1), .co(co1)
  );
  somador_completo #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .ci(ci4), .s(s4), .co(co4)
  );
  somador_completo #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .ci(ci8), .s(s8), .co(co8)
  );

  // Wait until the outputs for the inputs just applied are valid.
  task automatic settle();
`ifdef SOMADOR_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #10;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a4  = 4'h9;
    b4  = 4'h8;
    ci4 = 1'b1;
`ifdef SOMADOR_REG_OUT_EN
    for (int k = 0; k < 2; k++) begin
      settle();
      checks++;
      if ({co4, s4} !== 5'b0_0000) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got co=%b s=%h, want co=0 s=0", k, co4, s4);
      end
    end
    rst = 1'b0;
    settle();
    checks++;
    if ({co4, s4} !== 5'b1_0010) begin
      errors++;
      $display("FAIL reset_release: got co=%b s=%h, want co=1 s=2", co4, s4);
    end
`else
    // Combinational build: rst has no effect on the result.
    settle();
    checks++;
    if ({co4, s4} !== 5'b1_0010) begin
      errors++;
      $display("FAIL reset_ignored: got co=%b s=%h, want co=1 s=2", co4, s4);
    end
    rst = 1'b0;
`endif
  endtask

  task automatic test_truth_table();
    // Expected {s, co} for (a,b,ci) = 000 .. 111.
    logic [1:0] tt_exp [8];
    logic [2:0] v;
    tt_exp = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 8; i++) begin
      v   = 3'(i);
      a1  = v[2];
      b1  = v[1];
      ci1 = v[0];
      settle();
      checks++;
      if ({s1, co1} !== tt_exp[i]) begin
        errors++;
        $display("FAIL truth_table[%b]: got s,co=%b%b, want %b", v, s1, co1, tt_exp[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0;
    settle();
    checks++;
    if ({co8, s8} !== 9'h100) begin
      errors++;
      $display("FAIL wrap_ff_01: got co=%b s=%h, want co=1 s=00", co8, s8);
    end
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    settle();
    checks++;
    if ({co8, s8} !== 9'h1FF) begin
      errors++;
      $display("FAIL max_ff_ff_1: got co=%b s=%h, want co=1 s=ff", co8, s8);
    end
    a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b1;
    settle();
    checks++;
    if ({co8, s8} !== 9'h100) begin
      errors++;
      $display("FAIL wrap_ff_00_1: got co=%b s=%h, want co=1 s=00", co8, s8);
    end
  endtask

  task automatic test_random();
    logic [8:0] exp;
    for (int i = 0; i < 1000; i++) begin
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      ci8 = 1'($urandom);
      exp = {1'b0, a8} + {1'b0, b8} + {8'h00, ci8};
      settle();
      checks++;
      if ({co8, s8} !== exp) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h ci=%b: got %h, want %h",
                 i, a8, b8, ci8, {co8, s8}, exp);
      end
    end
  endtask

`ifdef SOMADOR_REG_OUT_EN
  task automatic test_back_to_back();
    // Each new vector is applied right after the previous capture edge, so
    // results must appear on consecutive edges with no gap.
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b0; ci1 = 1'b1;
    settle();
    checks++;
    if ({s1, co1} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_first: got s,co=%b%b, want 10", s1, co1);
    end
    a1 = 1'b1; b1 = 1'b1; ci1 = 1'b0;
    settle();
    checks++;
    if ({s1, co1} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_second: got s,co=%b%b, want 01", s1, co1);
    end
    a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
    rst = 1'b1;
    settle();
    checks++;
    if ({s1, co1} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_reset: got s,co=%b%b, want 00", s1, co1);
    end
    rst = 1'b0;
    settle();
    checks++;
    if ({s1, co1} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_after_reset: got s,co=%b%b, want 11", s1, co1);
    end
  endtask
`else
  task automatic test_back_to_back();
    // Combinational build: clock and reset activity must not disturb outputs.
    a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({s1, co1} !== 2'b11) begin
      errors++;
      $display("FAIL comb_rst_edge: got s,co=%b%b, want 11", s1, co1);
    end
    rst = 1'b0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    test_reset();
    test_truth_table();
    test_boundaries();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_somador_completo
